// File: rtl/shift_exec_stage_if.sv
// Request/result handshake bundle for the shift execute stage.
//   master: issues shift requests (in_*) and consumes results (out_ready)
//   slave : the stage; returns in_ready and the registered result (out_*)
interface shift_exec_stage_if;
  localparam int unsigned DW  = 32;
  localparam int unsigned SHW = 5;
  localparam int unsigned TW  = 5;

  // request channel
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_type;
  logic          in_var;
  logic [SHW-1:0] in_shamt;
  logic [DW-1:0] in_rs;
  logic [DW-1:0] in_T;

  // result channel
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_Y;
  logic          out_C;
  logic          out_N;
  logic          out_Z;
  logic          out_err;

  modport master (
    output in_valid, in_type, in_var, in_shamt, in_rs, in_T, out_ready,
    input  in_ready, out_valid, out_Y, out_C, out_N, out_Z, out_err
  );

  modport slave (
    input  in_valid, in_type, in_var, in_shamt, in_rs, in_T, out_ready,
    output in_ready, out_valid, out_Y, out_C, out_N, out_Z, out_err
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-stage execute wrapper around an external combinational barrel shifter.
// S1 registers the operands and drives the shifter; S2 captures the shifter
// result with N/Z flags and presents it to the ALU result mux.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   bus (slave)         in_* request handshake, out_* result handshake
//   sh_T/sh_shamt/sh_type  registered shifter operands (sh_type=0 when S1 empty)
//   sh_Y/sh_C           combinational shifter result
module shift_exec_stage #(
  parameter int unsigned DW  = 32,
  parameter int unsigned SHW = 5
) (
  input  logic              clk,
  input  logic              reset,
  shift_exec_stage_if.slave bus,
  output logic [DW-1:0]     sh_T,
  output logic [SHW-1:0]    sh_shamt,
  output logic [4:0]        sh_type,
  input  logic [DW-1:0]     sh_Y,
  input  logic              sh_C
);

  localparam logic [4:0] TYPE_SLL  = 5'h0C;
  localparam logic [4:0] TYPE_SRL  = 5'h0D;
  localparam logic [4:0] TYPE_SRA  = 5'h0E;
  localparam logic [4:0] TYPE_IDLE = 5'h00;

  // S1 state
  logic           s1_valid_q, s1_valid_d;
  logic           s1_err_q,   s1_err_d;
  logic [DW-1:0]  sh_T_q,     sh_T_d;
  logic [SHW-1:0] sh_shamt_q, sh_shamt_d;
  logic [4:0]     sh_type_q,  sh_type_d;

  // S2 state
  logic           s2_valid_q, s2_valid_d;
  logic [DW-1:0]  out_Y_q,    out_Y_d;
  logic           out_C_q,    out_C_d;
  logic           out_N_q,    out_N_d;
  logic           out_Z_q,    out_Z_d;
  logic           out_err_q,  out_err_d;

  logic           in_ready_c;
  logic           in_accept_c;
  logic           s2_load_c;
  logic           s2_drain_c;
  logic           type_legal_c;
  logic           unused_rs_c;

  // Only rs[4:0] is a shift amount; the upper bits are deliberately ignored.
  assign unused_rs_c = ^bus.in_rs[DW-1:SHW];

  assign type_legal_c = (bus.in_type == TYPE_SLL) || (bus.in_type == TYPE_SRL) ||
                        (bus.in_type == TYPE_SRA);

  // S2 can take S1 whenever it is empty or its result leaves this cycle.
  assign s2_drain_c  = s2_valid_q & bus.out_ready;
  assign s2_load_c   = s1_valid_q & (~s2_valid_q | bus.out_ready);
  // Depends on out_ready but never on in_valid.
  assign in_ready_c  = ~s1_valid_q | ~s2_valid_q | bus.out_ready;
  assign in_accept_c = bus.in_valid & in_ready_c;

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_err_d   = s1_err_q;
    sh_T_d     = sh_T_q;
    sh_shamt_d = sh_shamt_q;
    sh_type_d  = sh_type_q;
    s2_valid_d = s2_valid_q;
    out_Y_d    = out_Y_q;
    out_C_d    = out_C_q;
    out_N_d    = out_N_q;
    out_Z_d    = out_Z_q;
    out_err_d  = out_err_q;

    if (s2_load_c) begin
      s2_valid_d = 1'b1;
      if (s1_err_q) begin
        // Illegal request: deterministic zero result flagged as error.
        out_Y_d   = '0;
        out_C_d   = 1'b0;
        out_N_d   = 1'b0;
        out_Z_d   = 1'b1;
        out_err_d = 1'b1;
      end else begin
        out_Y_d   = sh_Y;
        out_C_d   = sh_C;
        out_N_d   = sh_Y[DW-1];
        out_Z_d   = (sh_Y == '0);
        out_err_d = 1'b0;
      end
    end else if (s2_drain_c) begin
      s2_valid_d = 1'b0;
    end

    if (in_accept_c) begin
      s1_valid_d = 1'b1;
      s1_err_d   = ~type_legal_c;
      sh_T_d     = bus.in_T;
      sh_shamt_d = bus.in_var ? bus.in_rs[SHW-1:0] : bus.in_shamt;
      sh_type_d  = type_legal_c ? bus.in_type : TYPE_IDLE;
    end else if (s2_load_c) begin
      // S1 empties: park the shifter on the idle type.
      s1_valid_d = 1'b0;
      s1_err_d   = 1'b0;
      sh_type_d  = TYPE_IDLE;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      sh_T_q     <= '0;
      sh_shamt_q <= '0;
      sh_type_q  <= TYPE_IDLE;
      s2_valid_q <= 1'b0;
      out_Y_q    <= '0;
      out_C_q    <= 1'b0;
      out_N_q    <= 1'b0;
      out_Z_q    <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      sh_T_q     <= sh_T_d;
      sh_shamt_q <= sh_shamt_d;
      sh_type_q  <= sh_type_d;
      s2_valid_q <= s2_valid_d;
      out_Y_q    <= out_Y_d;
      out_C_q    <= out_C_d;
      out_N_q    <= out_N_d;
      out_Z_q    <= out_Z_d;
      out_err_q  <= out_err_d;
    end
  end

  assign sh_T          = sh_T_q;
  assign sh_shamt      = sh_shamt_q;
  assign sh_type       = sh_type_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_Y     = out_Y_q;
  assign bus.out_C     = out_C_q;
  assign bus.out_N     = out_N_q;
  assign bus.out_Z     = out_Z_q;
  assign bus.out_err   = out_err_q;

endmodule
